sobel_pix_packer: RTL and testbench
===================================

// Module: sobel_pix_packer
// PURPOSE
//   Packs the 16-bit RGB565 edge-map stream from the Sobel stage into 256-bit words for the DDR3 write FIFO.
//   Sits between vip (post_frame_vsync/de/rgb) and ddr_interface (datain_valid/datain/wr_load).
//   Adds frame framing, ping-pong bank selection, line/frame counting and error flags.
//   Runs entirely in the camera pixel clock domain; the CDC is handled by the downstream FIFO.
// PARAMETERS
//   PIX_W     16    bits per pixel
//   WORD_W    256   packed word width; PPW = WORD_W/PIX_W = 16 pixels/word (localparam, must divide exactly)
//   H_PIXEL   1024  active pixels per line
//   V_PIXEL   768   active lines per frame
//   PINGPANG  1     1: toggle bank every frame; 0: bank stays 0
// PORTS
//   clk          in   1       camera pixel clock (cam_pclk)
//   rst          in   1       asynchronous, active-high reset
//   frame_vsync  in   1       post_frame_vsync, active-high frame-start pulse/level
//   pix_de       in   1       pixel valid
//   pix_data     in   PIX_W   RGB565 pixel
//   fifo_full    in   1       downstream write FIFO full
//   word_valid   out  1       one-cycle strobe: word_data is valid this cycle
//   word_data    out  WORD_W  packed word, pixel 0 in [15:0], pixel 15 in [255:240]
//   frame_start  out  1       one-cycle pulse on vsync rising edge (drives wr_load)
//   frame_done   out  1       one-cycle pulse when H_PIXEL*V_PIXEL pixels accepted
//   bank         out  1       active ping-pong bank
//   line_cnt     out  10      current line index (0..V_PIXEL-1)
//   err_overflow out  1       sticky: word dropped because fifo_full
//   err_short    out  1       sticky: line ended or frame restarted with a partial word
// BEHAVIOUR
//   Reset: all outputs 0, state WAIT_SYNC, pixel/word counters and shift register 0.
//   vsync edge: vsync_d registered; rise = vsync & ~vsync_d.
//   States:
//     WAIT_SYNC: ignore pix_de; on rise -> ACTIVE, pulse frame_start, toggle bank (if PINGPANG).
//     ACTIVE: pack pixels when pix_de=1 and vsync=0; at H_PIXEL*V_PIXEL pixels -> DONE, pulse frame_done.
//     DONE: discard pix_de; on rise -> ACTIVE (same actions as from WAIT_SYNC).
//   Rise while in ACTIVE: restart frame (counters cleared, frame_start, bank toggle);
//     pending partial word discarded, err_short set.
//   pix_de during vsync=1 is ignored (vsync takes priority on the same cycle).
//   Packing: slot counter 0..15; pixel written to slot, slot++; on the 16th pixel,
//     word_valid=1 on the NEXT cycle (latency 1) with the full word; slot wraps to 0.
//   Back-to-back pixels sustain 1 word per 16 clocks with no bubble.
//   Line end = pix_de falling edge in ACTIVE: if slot!=0, emit word zero-padded in unused slots,
//     set err_short, clear slot; line_cnt++ (saturates at V_PIXEL-1); pixel-in-line count cleared.
//   Pixels beyond H_PIXEL in a line are dropped (not packed, not counted).
//   fifo_full sampled on the emit cycle: if 1, word_valid stays 0, word is lost, err_overflow set;
//     packing continues (no backpressure upstream exists).
//   Sticky errors clear only on rst.
//   Frame pixel counter is 20 bits; compares to H_PIXEL*V_PIXEL (786432) exactly.
//   bank updates in the same cycle as frame_start.
//   Reset mid-frame: immediate return to reset state; no partial word is emitted.
// TESTING
//   1) Reset, vsync pulse, 16 pixels 0x0001..0x0010 -> frame_start=1 once, bank=1, one word_valid
//      one cycle after the 16th pixel, word_data[15:0]=0x0001, [255:240]=0x0010.
//   2) Full 1024x768 frame, continuous de per line -> 49152 word_valid, line_cnt reaches 767,
//      frame_done pulses exactly once, no errors; second frame -> bank back to 0.
//   3) Line of 1000 pixels -> 62 full words plus 1 word with slots 8..15 = 0, err_short=1.
//   4) fifo_full=1 on the cycle the 3rd word is due -> word_valid stays low for that word only,
//      err_overflow=1, 4th word emitted normally 16 pixels later.
//   5) vsync rise mid-line with slot=5 -> no word emitted, err_short=1, frame_start pulse,
//      counters cleared, next 16 pixels form word 0 of the new frame.
//   6) pix_de=1 with vsync=1 in the same cycle, and pixels after frame_done -> ignored;
//      word count unchanged.

Source files
------------

// File: rtl/sobel_pix_packer.sv
// Packs the RGB565 Sobel edge stream into wide words for the DDR write FIFO.
// Handles frame framing, ping-pong bank selection, line counting and sticky error flags.
module sobel_pix_packer #(
    parameter int PIX_W    = 16,
    parameter int WORD_W   = 256,
    parameter int H_PIXEL  = 1024,
    parameter int V_PIXEL  = 768,
    parameter int PINGPANG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_vsync,
    input  logic              pix_de,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              fifo_full,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data,
    output logic              frame_start,
    output logic              frame_done,
    output logic              bank,
    output logic [9:0]        line_cnt,
    output logic              err_overflow,
    output logic              err_short
);

    localparam int PPW    = WORD_W / PIX_W;
    localparam int SLOT_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int LPIX_W = $clog2(H_PIXEL + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(PPW - 1);
    localparam logic [SLOT_W-1:0] SLOT_ZERO = SLOT_W'(0);
    localparam logic [LPIX_W-1:0] H_LIM     = LPIX_W'(H_PIXEL);
    localparam logic [19:0]       FRAME_PIX = 20'(H_PIXEL * V_PIXEL);
    localparam logic [9:0]        V_LAST    = 10'(V_PIXEL - 1);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        ACTIVE    = 2'd1,
        DONE      = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                vsync_q;
    logic                de_q;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [WORD_W-1:0]   sreg_q, sreg_d;
    logic [LPIX_W-1:0]   lpix_q, lpix_d;
    logic [19:0]         fpix_q, fpix_d;
    logic                word_valid_q, word_valid_d;
    logic [WORD_W-1:0]   word_data_q, word_data_d;
    logic                frame_start_q, frame_start_d;
    logic                frame_done_q, frame_done_d;
    logic                bank_q, bank_d;
    logic [9:0]          line_cnt_q, line_cnt_d;
    logic                err_ovf_q, err_ovf_d;
    logic                err_short_q, err_short_d;

    logic                rise_s;
    logic                de_eff_s;
    logic                fall_s;
    logic                take_s;
    logic                emit_s;
    logic [WORD_W-1:0]   emit_word_s;
    logic [WORD_W-1:0]   filled_s;

    // Edge detection and the pixel-accept qualifier; vsync masks pix_de on the same cycle.
    always_comb begin
        rise_s   = frame_vsync & ~vsync_q;
        de_eff_s = pix_de & ~frame_vsync;
        fall_s   = de_q & ~de_eff_s;
        take_s   = (state_q == ACTIVE) && de_eff_s && (lpix_q < H_LIM);
        filled_s = sreg_q;
        filled_s[int'(slot_q) * PIX_W +: PIX_W] = pix_data;
    end

    // Next-state logic for framing, packing, line counting and error flags.
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        sreg_d        = sreg_q;
        lpix_d        = lpix_q;
        fpix_d        = fpix_q;
        bank_d        = bank_q;
        line_cnt_d    = line_cnt_q;
        err_short_d   = err_short_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        emit_s        = 1'b0;
        emit_word_s   = sreg_q;

        if (rise_s) begin
            // A rising vsync restarts framing from any state; a pending partial word is dropped.
            state_d       = ACTIVE;
            frame_start_d = 1'b1;
            bank_d        = (PINGPANG != 0) ? ~bank_q : 1'b0;
            slot_d        = SLOT_ZERO;
            sreg_d        = '0;
            lpix_d        = '0;
            fpix_d        = 20'd0;
            line_cnt_d    = 10'd0;
            if ((state_q == ACTIVE) && (slot_q != SLOT_ZERO)) begin
                err_short_d = 1'b1;
            end else begin
                err_short_d = err_short_q;
            end
        end else begin
            case (state_q)
                WAIT_SYNC: begin
                    state_d = WAIT_SYNC;
                end
                ACTIVE: begin
                    if (take_s) begin
                        lpix_d = lpix_q + LPIX_W'(1);
                        fpix_d = fpix_q + 20'd1;
                        if (slot_q == SLOT_LAST) begin
                            emit_s      = 1'b1;
                            emit_word_s = filled_s;
                            slot_d      = SLOT_ZERO;
                            sreg_d      = '0;
                        end else begin
                            slot_d = slot_q + SLOT_W'(1);
                            sreg_d = filled_s;
                        end
                        if (fpix_q + 20'd1 == FRAME_PIX) begin
                            state_d      = DONE;
                            frame_done_d = 1'b1;
                        end else begin
                            state_d = ACTIVE;
                        end
                    end else if (fall_s) begin
                        // Unused slots are already zero, so the flushed word is zero-padded.
                        if (slot_q != SLOT_ZERO) begin
                            emit_s      = 1'b1;
                            emit_word_s = sreg_q;
                            err_short_d = 1'b1;
                        end else begin
                            emit_s = 1'b0;
                        end
                        slot_d = SLOT_ZERO;
                        sreg_d = '0;
                        lpix_d = '0;
                        if (line_cnt_q != V_LAST) begin
                            line_cnt_d = line_cnt_q + 10'd1;
                        end else begin
                            line_cnt_d = line_cnt_q;
                        end
                    end else begin
                        state_d = ACTIVE;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = WAIT_SYNC;
                end
            endcase
        end
    end

    // Output word strobe; fifo_full is sampled when the word is formed and a full FIFO loses the word.
    always_comb begin
        word_data_d  = word_data_q;
        word_valid_d = 1'b0;
        err_ovf_d    = err_ovf_q;
        if (emit_s) begin
            word_data_d = emit_word_s;
            if (fifo_full) begin
                err_ovf_d = 1'b1;
            end else begin
                word_valid_d = 1'b1;
            end
        end else begin
            word_valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= WAIT_SYNC;
            vsync_q       <= 1'b0;
            de_q          <= 1'b0;
            slot_q        <= SLOT_ZERO;
            sreg_q        <= '0;
            lpix_q        <= '0;
            fpix_q        <= 20'd0;
            word_valid_q  <= 1'b0;
            word_data_q   <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            bank_q        <= 1'b0;
            line_cnt_q    <= 10'd0;
            err_ovf_q     <= 1'b0;
            err_short_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            vsync_q       <= frame_vsync;
            de_q          <= de_eff_s;
            slot_q        <= slot_d;
            sreg_q        <= sreg_d;
            lpix_q        <= lpix_d;
            fpix_q        <= fpix_d;
            word_valid_q  <= word_valid_d;
            word_data_q   <= word_data_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            bank_q        <= bank_d;
            line_cnt_q    <= line_cnt_d;
            err_ovf_q     <= err_ovf_d;
            err_short_q   <= err_short_d;
        end
    end

    assign word_valid   = word_valid_q;
    assign word_data    = word_data_q;
    assign frame_start  = frame_start_q;
    assign frame_done   = frame_done_q;
    assign bank         = bank_q;
    assign line_cnt     = line_cnt_q;
    assign err_overflow = err_ovf_q;
    assign err_short    = err_short_q;

endmodule

// File: tb/tb_sobel_pix_packer.sv
// Directed bench for sobel_pix_packer on a reduced 64x4 frame (4 words per line, 16 per frame).
module tb_sobel_pix_packer;

    localparam int H = 64;
    localparam int V = 4;

    logic         clk;
    logic         rst;
    logic         frame_vsync;
    logic         pix_de;
    logic [15:0]  pix_data;
    logic         fifo_full;
    logic         word_valid;
    logic [255:0] word_data;
    logic         frame_start;
    logic         frame_done;
    logic         bank;
    logic [9:0]   line_cnt;
    logic         err_overflow;
    logic         err_short;

    int n_assert = 0;
    int n_fail   = 0;
    int wc = 0;
    int fs = 0;
    int fd = 0;
    int wc0;
    int fs0;
    int fd0;
    logic [255:0] last_word = '0;
    logic [255:0] exp_w;

    sobel_pix_packer #(
        .PIX_W(16), .WORD_W(256), .H_PIXEL(H), .V_PIXEL(V), .PINGPANG(1)
    ) dut (
        .clk(clk), .rst(rst), .frame_vsync(frame_vsync), .pix_de(pix_de),
        .pix_data(pix_data), .fifo_full(fifo_full), .word_valid(word_valid),
        .word_data(word_data), .frame_start(frame_start), .frame_done(frame_done),
        .bank(bank), .line_cnt(line_cnt), .err_overflow(err_overflow), .err_short(err_short)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (word_valid) begin
                wc = wc + 1;
                last_word = word_data;
            end
            if (frame_start) fs = fs + 1;
            if (frame_done) fd = fd + 1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pix(input logic [15:0] d);
        pix_de = 1'b1;
        pix_data = d;
        step(1);
    endtask

    task automatic line(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) pix(base + 16'(i));
        pix_de = 1'b0;
        step(2);
    endtask

    task automatic vs();
        frame_vsync = 1'b1;
        step(1);
        frame_vsync = 1'b0;
        step(1);
    endtask

    initial begin
        rst = 1'b1; frame_vsync = 1'b0; pix_de = 1'b0; pix_data = 16'd0; fifo_full = 1'b0;
        step(3);
        chk("rst_wv", int'(word_valid), 0);
        chk("rst_fs", int'(frame_start), 0);
        chk("rst_fd", int'(frame_done), 0);
        chk("rst_bank", int'(bank), 0);
        chk("rst_line", int'(line_cnt), 0);
        chk("rst_ovf", int'(err_overflow), 0);
        chk("rst_short", int'(err_short), 0);
        chkw("rst_data", word_data, 256'd0);
        rst = 1'b0;
        step(2);

        // 1) first frame, first word
        frame_vsync = 1'b1;
        step(1);
        chk("t1_fs_pulse", int'(frame_start), 1);
        chk("t1_bank", int'(bank), 1);
        frame_vsync = 1'b0;
        step(1);
        chk("t1_fs_low", int'(frame_start), 0);
        for (int i = 1; i <= 16; i++) begin
            pix(16'(i));
            if (i == 15) chk("t1_no_early_wv", int'(word_valid), 0);
        end
        chk("t1_wv", int'(word_valid), 1);
        for (int k = 0; k < 16; k++) exp_w[k*16 +: 16] = 16'(k + 1);
        chkw("t1_word", word_data, exp_w);
        pix_de = 1'b0;
        step(1);
        chk("t1_wv_one_cycle", int'(word_valid), 0);
        chk("t1_wc", wc, 1);
        chk("t1_fs_cnt", fs, 1);

        // 2) full frame
        wc0 = wc; fd0 = fd;
        vs();
        chk("t2_bank", int'(bank), 0);
        for (int l = 0; l < V; l++) line(H, 16'(l * H));
        chk("t2_words", wc - wc0, 16);
        chk("t2_done_once", fd - fd0, 1);
        chk("t2_line", int'(line_cnt), V - 1);
        chk("t2_short", int'(err_short), 0);
        chk("t2_ovf", int'(err_overflow), 0);
        for (int k = 0; k < 16; k++) exp_w[k*16 +: 16] = 16'(240 + k);
        chkw("t2_last_word", last_word, exp_w);

        // 6b) pixels after frame_done are ignored
        wc0 = wc;
        line(16, 16'h5555);
        chk("t6_after_done_words", wc - wc0, 0);
        chk("t6_after_done_line", int'(line_cnt), V - 1);

        // 3) short line, then over-long line
        vs();
        chk("t3_bank", int'(bank), 1);
        wc0 = wc;
        line(40, 16'h0100);
        chk("t3_words", wc - wc0, 3);
        exp_w = '0;
        for (int k = 0; k < 8; k++) exp_w[k*16 +: 16] = 16'h0120 + 16'(k);
        chkw("t3_pad_word", last_word, exp_w);
        chk("t3_short", int'(err_short), 1);
        chk("t3_line", int'(line_cnt), 1);
        wc0 = wc;
        line(70, 16'h0200);
        chk("t3_long_words", wc - wc0, 4);
        for (int k = 0; k < 16; k++) exp_w[k*16 +: 16] = 16'h0230 + 16'(k);
        chkw("t3_long_last", last_word, exp_w);
        chk("t3_long_line", int'(line_cnt), 2);

        // 4) fifo_full on the third word
        vs();
        chk("t4_bank", int'(bank), 0);
        wc0 = wc;
        for (int i = 0; i < 64; i++) begin
            fifo_full = (i == 47);
            pix(16'h0300 + 16'(i));
            if (i == 31) chk("t4_w2_valid", int'(word_valid), 1);
            if (i == 47) chk("t4_w3_dropped", int'(word_valid), 0);
        end
        fifo_full = 1'b0;
        chk("t4_w4_valid", int'(word_valid), 1);
        for (int k = 0; k < 16; k++) exp_w[k*16 +: 16] = 16'h0330 + 16'(k);
        chkw("t4_w4_data", word_data, exp_w);
        pix_de = 1'b0;
        step(2);
        chk("t4_words", wc - wc0, 3);
        chk("t4_ovf", int'(err_overflow), 1);

        // reset mid-frame with a partial word pending
        vs();
        for (int i = 0; i < 7; i++) pix(16'h0700 + 16'(i));
        wc0 = wc;
        rst = 1'b1;
        pix_de = 1'b0;
        step(1);
        chk("rstm_bank", int'(bank), 0);
        chk("rstm_line", int'(line_cnt), 0);
        chk("rstm_ovf", int'(err_overflow), 0);
        chk("rstm_short", int'(err_short), 0);
        rst = 1'b0;
        step(2);
        chk("rstm_no_word", wc - wc0, 0);

        // 5) vsync rise mid-line with slot 5, de held high during vsync
        vs();
        chk("t5_bank", int'(bank), 1);
        for (int i = 0; i < 5; i++) pix(16'h0400 + 16'(i));
        chk("t5_short_before", int'(err_short), 0);
        fs0 = fs;
        frame_vsync = 1'b1;
        pix_de = 1'b1;
        pix_data = 16'hDEAD;
        step(1);
        chk("t5_fs_pulse", int'(frame_start), 1);
        chk("t5_short", int'(err_short), 1);
        chk("t5_bank_toggle", int'(bank), 0);
        frame_vsync = 1'b0;
        for (int i = 0; i < 16; i++) pix(16'h0500 + 16'(i));
        chk("t5_wv", int'(word_valid), 1);
        for (int k = 0; k < 16; k++) exp_w[k*16 +: 16] = 16'h0500 + 16'(k);
        chkw("t5_word0", word_data, exp_w);
        pix_de = 1'b0;
        step(2);
        chk("t5_words", wc - wc0, 1);
        chk("t5_fs_cnt", fs - fs0, 1);
        chk("t5_line", int'(line_cnt), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
